rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream resource among 2**WIDTH requesters.
- Each grant is presented in two encodings, kept coherent at all times:
  - one-hot vector, for mux select;
  - binary index, for tagging and steering.
- Grants are locked across multi-beat transfers.
- A beat-count limit prevents a single requester from monopolising the resource.
- Sits between requester agents and the shared datapath. Produces the one-hot select plus the matching binary index consumed by downstream tag logic.

---
 rtl/rr_onehot_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// rr_onehot_arbiter
//   Round-robin arbiter sharing one downstream resource among 2**WIDTH
//   requesters. A grant is locked for a multi-beat transfer. It is released
//   on an accepted last beat, on the MAX_BEATS-th accepted beat (preempt), or
//   when the owner drops its request without a beat being accepted (abort).
//   On release, arbitration reruns in the same cycle. The pointer is rotated
//   past the previous owner, so back-to-back grants have no bubble.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req         in   [N-1:0] request levels
//   gnt_onehot  out  [N-1:0] registered one-hot grant, zero when idle
//   gnt_bin     out  [WIDTH-1:0] registered grant index, zero when idle
//   gnt_valid   out  grant active, beat offered downstream
//   gnt_ready   in   downstream accepts the current beat
//   gnt_last    in   current beat is the final one (used only when accepted)
//   preempt     out  one-cycle pulse: grant released at MAX_BEATS
//   abort       out  one-cycle pulse: grant dropped because owner's req fell
//   error       out  sticky coherence flag for the registered grant outputs
// ---------------------------------------------------------------------------
module rr_onehot_arbiter #(
   parameter  int WIDTH     = 4,
   parameter  int MAX_BEATS = 16,
   localparam int N         = 1 << WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt_onehot,
   output logic [WIDTH-1:0] gnt_bin,
   output logic             gnt_valid,
   input  logic             gnt_ready,
   input  logic             gnt_last,
   output logic             preempt,
   output logic             abort,
   output logic             error
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

   state_t           state_q, state_d;
   logic [N-1:0]     onehot_q, onehot_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] ptr_q, ptr_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             preempt_q, preempt_d;
   logic             abort_q, abort_d;
   logic             error_q, error_d;

   logic             busy, beat, at_max, complete, abort_cond, release_gnt;
   logic [WIDTH-1:0] arb_ptr, scan_idx, win_idx;
   logic             win_found;
   logic             incoherent;

   assign busy        = (state_q == BUSY);
   assign beat        = busy && gnt_ready;
   assign at_max      = (cnt_q == LAST_CNT);
   assign complete    = beat && (gnt_last || at_max);
   // An accepted beat wins over a dropped request in the same cycle.
   assign abort_cond  = busy && !gnt_ready && !req[bin_q];
   assign release_gnt = complete || abort_cond;

   // On release the scan starts just past the current owner, making it the
   // lowest priority; otherwise the stored pointer is used.
   assign arb_ptr = release_gnt ? bin_q + WIDTH'(1) : ptr_q;

   // NOTE: every combinational output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int i = 0; i < N; i++) begin
         scan_idx = arb_ptr + WIDTH'(i);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      onehot_d  = onehot_q;
      bin_d     = bin_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      abort_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d  = BUSY;
               onehot_d = N'(1) << win_idx;
               bin_d    = win_idx;
               cnt_d    = '0;
            end
         end
         BUSY: begin
            if (release_gnt) begin
               ptr_d     = bin_q + WIDTH'(1);
               preempt_d = beat && !gnt_last && at_max;
               abort_d   = abort_cond;
               cnt_d     = '0;
               if (win_found) begin
                  onehot_d = N'(1) << win_idx;
                  bin_d    = win_idx;
               end else begin
                  state_d  = IDLE;
                  onehot_d = '0;
                  bin_d    = '0;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Coherence check on the registered outputs: while valid, exactly one bit
   // set and it matches the index; while idle, both encodings are zero.
   always_comb begin
      if (busy) begin
         incoherent = !$onehot(onehot_q) || (onehot_q != (N'(1) << bin_q));
      end else begin
         incoherent = (onehot_q != '0) || (bin_q != '0);
      end
      error_d = error_q || incoherent;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         onehot_q  <= '0;
         bin_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         preempt_q <= 1'b0;
         abort_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         onehot_q  <= onehot_d;
         bin_q     <= bin_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
         abort_q   <= abort_d;
         error_q   <= error_d;
      end
   end

   assign gnt_valid  = busy;
   assign gnt_onehot = onehot_q;
   assign gnt_bin    = bin_q;
   assign preempt    = preempt_q;
   assign abort      = abort_q;
   assign error      = error_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_onehot_arbiter
//   Directed bench for rr_onehot_arbiter (WIDTH=4, MAX_BEATS=16).
//   Inputs change and outputs are sampled on the falling clock edge; the DUT
//   acts on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

   localparam int WIDTH = 4;
   localparam int N     = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt_onehot;
   logic [WIDTH-1:0] gnt_bin;
   logic             gnt_valid;
   logic             gnt_ready;
   logic             gnt_last;
   logic             preempt;
   logic             abort;
   logic             error;

   int tests_run = 0;
   int tests_failed = 0;

   rr_onehot_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .gnt_onehot (gnt_onehot),
      .gnt_bin    (gnt_bin),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready),
      .gnt_last   (gnt_last),
      .preempt    (preempt),
      .abort      (abort),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_grant(input string tag, input int b);
      check({tag, "_valid"},  32'(gnt_valid),  32'd1);
      check({tag, "_bin"},    32'(gnt_bin),    32'(b));
      check({tag, "_onehot"}, 32'(gnt_onehot), 32'd1 << b);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, "_valid"},  32'(gnt_valid),  32'd0);
      check({tag, "_bin"},    32'(gnt_bin),    32'd0);
      check({tag, "_onehot"}, 32'(gnt_onehot), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      gnt_ready = 1'b0;
      gnt_last  = 1'b0;
      repeat (2) @(negedge clk);
      expect_idle("reset");
      check("reset_preempt", 32'(preempt), 32'd0);
      check("reset_abort",   32'(abort),   32'd0);
      check("reset_error",   32'(error),   32'd0);

      // Full round robin: every requester, one beat each, 0..15 then 0 again.
      rst_n     = 1'b1;
      req       = 16'hFFFF;
      gnt_ready = 1'b1;
      gnt_last  = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         expect_grant("rr", k % 16);
         if (k == 16) req = '0;
      end
      @(negedge clk);
      expect_idle("rr_end");
      check("rr_error", 32'(error), 32'd0);

      // 3-beat transfer on requester 4 with ready 1,0,1,1 (ptr=1 here).
      req       = 16'h0010;
      gnt_ready = 1'b1;
      gnt_last  = 1'b0;
      @(negedge clk); expect_grant("hs_a", 4);
      @(negedge clk); expect_grant("hs_b", 4); gnt_ready = 1'b0;
      @(negedge clk); expect_grant("hs_c", 4); gnt_ready = 1'b1;
      @(negedge clk); expect_grant("hs_d", 4); gnt_last = 1'b1; req = '0;
      @(negedge clk);
      expect_idle("hs_end");
      check("hs_abort", 32'(abort), 32'd0);

      // MAX_BEATS preemption on requester 2 (ptr=5 here).
      req       = 16'h0004;
      gnt_ready = 1'b1;
      gnt_last  = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         expect_grant("pre1", 2);
         check("pre1_nopulse", 32'(preempt), 32'd0);
      end
      @(negedge clk);
      expect_grant("pre1_regrant", 2);
      check("pre1_pulse", 32'(preempt), 32'd1);
      req = 16'h0024;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         expect_grant("pre2", 2);
         check("pre2_nopulse", 32'(preempt), 32'd0);
      end
      @(negedge clk);
      expect_grant("pre2_to5", 5);
      check("pre2_pulse", 32'(preempt), 32'd1);
      req      = '0;
      gnt_last = 1'b1;
      @(negedge clk);
      expect_idle("pre_end");
      check("pre_end_nopulse", 32'(preempt), 32'd0);

      // Build ptr=3 by completing a grant to 2, then req 1 and 2 together.
      req = 16'h0004;
      @(negedge clk); expect_grant("ptr_setup", 2); req = 16'h0006;
      @(negedge clk); expect_grant("ptr3_first", 1); req = 16'h0004;
      @(negedge clk); expect_grant("ptr3_second", 2); req = '0;
      @(negedge clk); expect_idle("ptr3_end");

      // Abort: requester 7 drops req while not ready (ptr=3 here).
      req       = 16'h0080;
      gnt_ready = 1'b0;
      gnt_last  = 1'b0;
      @(negedge clk); expect_grant("ab_grant", 7); req = '0;
      @(negedge clk); expect_idle("ab_drop"); check("ab_pulse", 32'(abort), 32'd1);
      @(negedge clk); check("ab_pulse_end", 32'(abort), 32'd0);

      // Drop coincides with an accepted beat: beat counts, grant stays.
      req = 16'h0080;
      @(negedge clk); expect_grant("ab2_grant", 7); req = '0; gnt_ready = 1'b1;
      @(negedge clk); expect_grant("ab2_beat", 7); check("ab2_nopulse", 32'(abort), 32'd0);
      gnt_ready = 1'b0;
      @(negedge clk); expect_idle("ab2_drop"); check("ab2_pulse", 32'(abort), 32'd1);

      // Reset mid-transfer on requester 9 (ptr=8 here).
      req = 16'h0200;
      @(negedge clk); expect_grant("rst_grant", 9);
      #2 rst_n = 1'b0;
      #1;
      expect_idle("rst_async");
      check("rst_preempt", 32'(preempt), 32'd0);
      check("rst_abort",   32'(abort),   32'd0);
      req = 16'h0201;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); expect_grant("rst_ptr0", 0);
      check("final_error", 32'(error), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
